// File: rtl/geofence_pkg.sv
// Shared types and width helpers for the convex-polygon geofence engine.
package geofence_pkg;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SORT   = 2'd1,
        ST_EVAL   = 2'd2,
        ST_RESULT = 2'd3
    } state_e;

    // Signed width of a coordinate difference.
    function automatic int unsigned diff_width(input int unsigned coord_w);
        return coord_w + 2;
    endfunction

    // Signed width of a cross product of two differences; never overflows.
    function automatic int unsigned cross_width(input int unsigned coord_w);
        return 2 * coord_w + 5;
    endfunction

    // Number of (i,j) pairs visited by the angular exchange sort.
    function automatic int unsigned pair_count(input int unsigned nv);
        return ((nv - 1) * (nv - 2)) / 2;
    endfunction

endpackage

// File: rtl/geofence_cross.sv
// Combinational signed 2-D cross product a x b = ax*by - ay*bx.
module geofence_cross #(
    parameter int unsigned DW = 12,
    parameter int unsigned CW = 25
) (
    input  logic signed [DW-1:0] ax_i,
    input  logic signed [DW-1:0] ay_i,
    input  logic signed [DW-1:0] bx_i,
    input  logic signed [DW-1:0] by_i,
    output logic signed [CW-1:0] cross_c
);

    logic signed [CW-1:0] ax_ext;
    logic signed [CW-1:0] ay_ext;
    logic signed [CW-1:0] bx_ext;
    logic signed [CW-1:0] by_ext;

    // Sign-extend first so products and the difference fit the full width.
    always_comb begin
        ax_ext  = CW'(ax_i);
        ay_ext  = CW'(ay_i);
        bx_ext  = CW'(bx_i);
        by_ext  = CW'(by_i);
        cross_c = (ax_ext * by_ext) - (ay_ext * bx_ext);
    end

endmodule

// File: rtl/geofence_poly.sv
// Convex-polygon geofence: load point + NV vertices, angular sort, edge tests.
// Optional boundary reporting is enabled by defining GEOFENCE_EDGE_EN.
module geofence_poly
    import geofence_pkg::*;
#(
    parameter int unsigned COORD_W = 10,
    parameter int unsigned NV      = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [COORD_W-1:0] X,
    input  logic [COORD_W-1:0] Y,
    output logic               ready,
    output logic               valid,
    output logic               is_inside,
    output logic               on_edge
);

    localparam int unsigned DW     = diff_width(COORD_W);
    localparam int unsigned CW     = cross_width(COORD_W);
    localparam int unsigned P      = pair_count(NV);
    localparam int unsigned IDX_W  = $clog2(NV);
    localparam int unsigned CNT_W  = $clog2(NV + 1);
    localparam int unsigned PAIR_W = $clog2(P + 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PAIR_W-1:0]    pair_q, pair_d;
    logic [IDX_W-1:0]     i_q, i_d, j_q, j_d, k_q, k_d;
    logic [COORD_W-1:0]   tx_q, tx_d, ty_q, ty_d;
    logic [COORD_W-1:0]   vx_q [NV];
    logic [COORD_W-1:0]   vx_d [NV];
    logic [COORD_W-1:0]   vy_q [NV];
    logic [COORD_W-1:0]   vy_d [NV];
    logic                 all_neg_q, all_neg_d;
    logic                 ready_q, ready_d;
    logic                 valid_q, valid_d;
    logic                 inside_q, inside_d;
`ifdef GEOFENCE_EDGE_EN
    logic                 any_pos_q, any_pos_d;
    logic                 edge_q, edge_d;
`endif

    logic [IDX_W-1:0]     kn_c;
    logic signed [DW-1:0] sa_x, sa_y, sb_x, sb_y;
    logic signed [DW-1:0] ea_x, ea_y, eb_x, eb_y;
    logic signed [CW-1:0] sort_c, eval_c;

    function automatic logic signed [DW-1:0] diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
        return $signed(DW'(a) - DW'(b));
    endfunction

    // Operand selection for the sort and edge-test cross products.
    always_comb begin
        kn_c = (k_q == IDX_W'(NV - 1)) ? '0 : k_q + IDX_W'(1);
        sa_x = diff(vx_q[i_q], vx_q[0]);
        sa_y = diff(vy_q[i_q], vy_q[0]);
        sb_x = diff(vx_q[j_q], vx_q[0]);
        sb_y = diff(vy_q[j_q], vy_q[0]);
        ea_x = diff(vx_q[k_q], tx_q);
        ea_y = diff(vy_q[k_q], ty_q);
        eb_x = diff(vx_q[kn_c], vx_q[k_q]);
        eb_y = diff(vy_q[kn_c], vy_q[k_q]);
    end

    geofence_cross #(.DW(DW), .CW(CW)) u_sort_cross (
        .ax_i    (sa_x),
        .ay_i    (sa_y),
        .bx_i    (sb_x),
        .by_i    (sb_y),
        .cross_c (sort_c)
    );

    geofence_cross #(.DW(DW), .CW(CW)) u_eval_cross (
        .ax_i    (ea_x),
        .ay_i    (ea_y),
        .bx_i    (eb_x),
        .by_i    (eb_y),
        .cross_c (eval_c)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pair_d    = pair_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        tx_d      = tx_q;
        ty_d      = ty_q;
        vx_d      = vx_q;
        vy_d      = vy_q;
        all_neg_d = all_neg_q;
`ifdef GEOFENCE_EDGE_EN
        any_pos_d = any_pos_q;
`endif

        case (state_q)
            ST_LOAD: begin
                if (in_valid && ready_q) begin
                    if (cnt_q == '0) begin
                        tx_d = X;
                        ty_d = Y;
                    end
                    for (int v = 0; v < int'(NV); v++) begin
                        if (cnt_q == CNT_W'(v + 1)) begin
                            vx_d[v] = X;
                            vy_d[v] = Y;
                        end
                    end
                    if (cnt_q == CNT_W'(NV)) begin
                        state_d = ST_SORT;
                        cnt_d   = '0;
                        pair_d  = '0;
                        i_d     = IDX_W'(1);
                        j_d     = IDX_W'(2);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_SORT: begin
                // Non-negative cross: V[j] is at least as far round as V[i], so exchange.
                if (!sort_c[CW-1]) begin
                    vx_d[i_q] = vx_q[j_q];
                    vy_d[i_q] = vy_q[j_q];
                    vx_d[j_q] = vx_q[i_q];
                    vy_d[j_q] = vy_q[i_q];
                end
                pair_d = pair_q + PAIR_W'(1);
                if (j_q == IDX_W'(NV - 1)) begin
                    i_d = i_q + IDX_W'(1);
                    j_d = i_q + IDX_W'(2);
                end else begin
                    j_d = j_q + IDX_W'(1);
                end
                if (pair_q == PAIR_W'(P - 1)) begin
                    state_d   = ST_EVAL;
                    k_d       = '0;
                    all_neg_d = 1'b1;
`ifdef GEOFENCE_EDGE_EN
                    any_pos_d = 1'b0;
`endif
                end
            end
            ST_EVAL: begin
                all_neg_d = all_neg_q & eval_c[CW-1];
`ifdef GEOFENCE_EDGE_EN
                any_pos_d = any_pos_q | (!eval_c[CW-1] && (eval_c != '0));
`endif
                k_d = kn_c;
                if (k_q == IDX_W'(NV - 1)) begin
                    state_d = ST_RESULT;
                end
            end
            ST_RESULT: begin
                state_d = ST_LOAD;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_LOAD;
                cnt_d   = '0;
            end
        endcase

        ready_d  = (state_d == ST_LOAD);
        valid_d  = (state_d == ST_RESULT);
        inside_d = valid_d & all_neg_d;
`ifdef GEOFENCE_EDGE_EN
        edge_d   = valid_d & !any_pos_d & !all_neg_d;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_LOAD;
            cnt_q     <= '0;
            pair_q    <= '0;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            tx_q      <= '0;
            ty_q      <= '0;
            for (int v = 0; v < int'(NV); v++) begin
                vx_q[v] <= '0;
                vy_q[v] <= '0;
            end
            all_neg_q <= 1'b0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            inside_q  <= 1'b0;
`ifdef GEOFENCE_EDGE_EN
            any_pos_q <= 1'b0;
            edge_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pair_q    <= pair_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            tx_q      <= tx_d;
            ty_q      <= ty_d;
            vx_q      <= vx_d;
            vy_q      <= vy_d;
            all_neg_q <= all_neg_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            inside_q  <= inside_d;
`ifdef GEOFENCE_EDGE_EN
            any_pos_q <= any_pos_d;
            edge_q    <= edge_d;
`endif
        end
    end

    assign ready     = ready_q;
    assign valid     = valid_q;
    assign is_inside = inside_q;
`ifdef GEOFENCE_EDGE_EN
    assign on_edge   = edge_q;
`else
    assign on_edge   = 1'b0;
`endif

endmodule

// File: doc/geofence_poly.md
# geofence_poly

Parametrised convex-polygon geofence engine: the generalised successor of the fixed hexagon geofence. Per frame it accepts one test point and `NV` unordered vertices, sorts the vertices angularly about vertex 0, and evaluates edge cross products sequentially. It reports inside/outside and, optionally, an on-boundary flag. It sits between the coordinate input stream and the result collector, and adds input flow control the fixed block lacks.

## Interface
- `COORD_W`, 10: unsigned coordinate width.
- `NV`, 6: polygon vertex count, legal 3..8.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: X/Y sample valid.
- `X` in `COORD_W`: sample X coordinate, unsigned.
- `Y` in `COORD_W`: sample Y coordinate, unsigned.
- `ready` out 1: block accepts a sample this cycle; a sample transfers when `in_valid & ready`.
- `valid` out 1: result strobe, one cycle.
- `is_inside` out 1: point strictly inside the polygon; meaningful only while `valid`=1, otherwise 0.
- `on_edge` out 1: point on the polygon boundary (see Configuration); meaningful only while `valid`=1, otherwise 0.

## Operation
- States:
  - LOAD: collect the test point, then the vertices.
  - SORT: angular sort of the vertices.
  - EVAL: per-edge tests.
  - RESULT: result strobe.
- LOAD:
  - `ready`=1.
  - Transfer 0 is the test point T. Transfers 1..NV are stored as V[0..NV-1].
  - Cycles with `in_valid`=0 are gaps; the count holds.
  - After transfer NV, go to SORT.
- SORT:
  - Exchange sort over index pairs (i,j), i=1..NV-2, j=i+1..NV-1, row-major, one pair per cycle.
  - c = (V[i]-V[0]) × (V[j]-V[0]).
  - If c ≥ 0, swap V[i] and V[j].
  - Takes P=(NV-1)(NV-2)/2 cycles, then go to EVAL. V[0] is never moved.
- EVAL:
  - One edge per cycle, k=0..NV-1.
  - e_k = (V[k]-T) × (V[(k+1) mod NV]-V[k]).
  - Accumulate `all_neg` (AND of e_k<0) and `any_pos` (OR of e_k>0).
  - Takes NV cycles, then go to RESULT.
- RESULT:
  - `valid`=1.
  - `is_inside`=`all_neg`.
  - `on_edge` per Configuration.
  - Next state LOAD with the transfer count cleared.
- `ready`=0 in SORT, EVAL and RESULT; `in_valid` is ignored there.
- Arithmetic:
  - Differences are sign-extended to `COORD_W`+2 signed bits.
  - Cross products are held in 2·`COORD_W`+5 signed bits, which has no overflow for any input.
- Polygon must be strictly convex (no three collinear vertices, no duplicates). Otherwise the result is undefined but the FSM still completes.
- Reset, asserted at any time (including mid-SORT or mid-EVAL), drives LOAD with the transfer count at 0 and all outputs 0. The partial frame is discarded.

## Timing
- Reset values: `ready`=0 while `reset`=0; `valid`=0; `is_inside`=0; `on_edge`=0. `ready`=1 from the first clock after deassertion.
- The last vertex transfers at edge t. SORT occupies cycles t+1..t+P, EVAL occupies t+P+1..t+P+NV, and `valid` is high during cycle t+P+NV+1.
- NV=6 gives P=10, so `valid` rises 17 cycles after the last vertex edge.
- `ready` rises in the cycle after `valid`. Back-to-back frames are therefore NV+1+P+NV+1 cycles apart minimum: 24 for NV=6.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.

## Configuration
- `GEOFENCE_EDGE_EN` defined:
  - `on_edge` = `!any_pos & !all_neg`, i.e. at least one e_k==0 and none positive.
  - `is_inside` stays strict, so boundary points report `is_inside`=0, `on_edge`=1.
- Undefined:
  - `on_edge` is tied to 0 and `any_pos` logic is removed.
  - Boundary points report `is_inside`=0.

## Structure
- Package `geofence_pkg` holds:
  - the state enumeration (LOAD, SORT, EVAL, RESULT);
  - width helper functions for the difference width (`COORD_W`+2) and the cross width (2·`COORD_W`+5);
  - the pair-count function P(NV).
- Sub-module `geofence_cross`: purely combinational signed cross product a×b of two difference vectors. Two instances: one for the SORT datapath, one for the EVAL datapath.

## Test plan
- Hexagon (400,300),(600,300),(700,500),(600,700),(400,700),(300,500), T=(500,500), continuous `in_valid` -> `valid` 17 cycles after the last vertex; `is_inside`=1, `on_edge`=0.
- Same hexagon, vertices presented scrambled as (600,700),(300,500),(600,300),(400,700),(700,500),(400,300), T=(0,0) -> `is_inside`=0, `on_edge`=0.
- Same hexagon, T=(500,300) -> with `GEOFENCE_EDGE_EN`: `is_inside`=0, `on_edge`=1; without it: `is_inside`=0, `on_edge`=0.
- `in_valid` toggled 1/0 every cycle during LOAD -> results identical to the first scenario; `ready` low from SORT until one cycle after `valid`.
- `reset` pulsed low at SORT cycle 4, followed by a fresh full frame (first scenario) -> no `valid` from the aborted frame; the fresh frame yields `is_inside`=1.
- NV=4, `COORD_W`=12, square (0,0),(4095,0),(4095,4095),(0,4095), T=(4095,2000) -> `valid` after P=3 plus 4 plus 1 cycles; `on_edge`=1 (macro on), no overflow.
